// File: rtl/pwd_unlock_pkg.sv
// Shared types and width helpers for the password-unlock controller.
package pwd_unlock_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StEntry,
      StUnlocked,
      StLockout
   } state_e;

   // Digit index width; at least one bit so a single-digit password still has a register.
   function automatic int unsigned idx_w(input int unsigned digits);
      return (digits > 1) ? $clog2(digits) : 1;
   endfunction

   function automatic int unsigned tmr_w(input int unsigned unlock_cycles,
                                         input int unsigned lockout_cycles);
      int unsigned m;
      m = (unlock_cycles > lockout_cycles) ? unlock_cycles : lockout_cycles;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/pwd_dwell_timer.sv
// Loadable down-counter; expired_o marks the last cycle of a loaded dwell period.
module pwd_dwell_timer #(
   parameter int unsigned Width = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [Width-1:0] value_i,
   output logic             expired_o
);

   logic [Width-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = value_i;
      end else if (count_q != '0) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Loading value V yields exactly V cycles before expiry takes effect.
   assign expired_o = (count_q == Width'(1));

endmodule

// File: rtl/pwd_unlock_ctrl.sv
// Password-unlock controller: symbol entry over valid/ready, fail counting, timed lockout
// and auto-relock.
module pwd_unlock_ctrl
   import pwd_unlock_pkg::*;
#(
   parameter int unsigned            N              = 4,
   parameter int unsigned            DIGITS         = 4,
   parameter int unsigned            MAX_FAILS      = 3,
   parameter int unsigned            LOCKOUT_CYCLES = 16,
   parameter int unsigned            UNLOCK_CYCLES  = 8,
   parameter logic [N*DIGITS-1:0]    DEFAULT_PWD    = 16'h1234
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [N-1:0]                   p_data,
   input  logic                           p_valid,
   output logic                           p_ready,
   input  logic                           pwd_wr,
   input  logic [N*DIGITS-1:0]            pwd_new,
   output logic                           unlock,
   output logic                           pwd_incorrect,
   output logic                           locked_out,
   output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);

   localparam int unsigned PwdW = N * DIGITS;
   localparam int unsigned IdxW = idx_w(DIGITS);
   localparam int unsigned TmrW = tmr_w(UNLOCK_CYCLES, LOCKOUT_CYCLES);
   localparam int unsigned FcW  = $clog2(MAX_FAILS + 1);

   localparam logic [IdxW-1:0] LastIdx    = IdxW'(DIGITS - 1);
   localparam logic [FcW-1:0]  MaxFails   = FcW'(MAX_FAILS);
   localparam logic [TmrW-1:0] UnlockLoad = TmrW'(UNLOCK_CYCLES);
   localparam logic [TmrW-1:0] LockLoad   = TmrW'(LOCKOUT_CYCLES);

   state_e          state_q, state_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic            mismatch_q, mismatch_d;
   logic [FcW-1:0]  fail_q, fail_d;
   logic [PwdW-1:0] pwd_q, pwd_d;
   logic            incorrect_q, incorrect_d;

   logic            ready;
   logic            xfer;
   logic [PwdW-1:0] pwd_shift;
   logic [N-1:0]    cur_digit;
   logic            mis_now;
   logic [FcW-1:0]  fail_inc;
   logic            tmr_load;
   logic [TmrW-1:0] tmr_value;
   logic            tmr_expired;

   assign ready     = (state_q == StIdle) || (state_q == StEntry);
   assign xfer      = p_valid && ready;
   // First-entered symbol is the most significant one, so shift the current digit to the top.
   assign pwd_shift = pwd_q << (N * idx_q);
   assign cur_digit = pwd_shift[PwdW-1 -: N];
   assign mis_now   = mismatch_q || (p_data != cur_digit);
   assign fail_inc  = (fail_q == MaxFails) ? fail_q : fail_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      mismatch_d  = mismatch_q;
      fail_d      = fail_q;
      pwd_d       = pwd_q;
      incorrect_d = 1'b0;
      tmr_load    = 1'b0;
      tmr_value   = '0;

      case (state_q)
         StIdle, StEntry: begin
            if (xfer) begin
               if (idx_q == LastIdx) begin
                  // Whole entry is always consumed before judging, so timing leaks nothing.
                  idx_d      = '0;
                  mismatch_d = 1'b0;
                  if (!mis_now) begin
                     state_d   = StUnlocked;
                     fail_d    = '0;
                     tmr_load  = 1'b1;
                     tmr_value = UnlockLoad;
                  end else begin
                     incorrect_d = 1'b1;
                     fail_d      = fail_inc;
                     if (fail_inc == MaxFails) begin
                        state_d   = StLockout;
                        tmr_load  = 1'b1;
                        tmr_value = LockLoad;
                     end else begin
                        state_d = StIdle;
                     end
                  end
               end else begin
                  idx_d      = idx_q + 1'b1;
                  mismatch_d = mis_now;
                  state_d    = StEntry;
               end
            end
         end
         StUnlocked: begin
            if (pwd_wr) begin
               pwd_d = pwd_new;
            end
            if (pwd_wr || tmr_expired) begin
               state_d = StIdle;
            end
         end
         StLockout: begin
            if (tmr_expired) begin
               state_d = StIdle;
               fail_d  = '0;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         mismatch_q  <= 1'b0;
         fail_q      <= '0;
         pwd_q       <= DEFAULT_PWD;
         incorrect_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         mismatch_q  <= mismatch_d;
         fail_q      <= fail_d;
         pwd_q       <= pwd_d;
         incorrect_q <= incorrect_d;
      end
   end

   pwd_dwell_timer #(
      .Width (TmrW)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (tmr_load),
      .value_i   (tmr_value),
      .expired_o (tmr_expired)
   );

   assign p_ready       = ready;
   assign unlock        = (state_q == StUnlocked);
   assign locked_out    = (state_q == StLockout);
   assign pwd_incorrect = incorrect_q;
   assign fail_cnt      = fail_q;

endmodule
